// File: rtl/framer_pkg.sv
// Shared types and helpers for the decision framer: FSM states, the decision
// word layout and the checksum/byte-select functions.
package framer_pkg;

    localparam int         DATA_MAX_W  = 64;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {IDLE, SOF, TYPE, DATA, CHK} fr_state_e;

    // Data is carried at the widest supported width; narrower instances zero-extend.
    typedef struct packed {
        logic [7:0]            dtype;
        logic [DATA_MAX_W-1:0] data;
    } decision_t;

    typedef struct packed {
        decision_t  dec;
        logic [7:0] chk;
    } hold_t;

    // Zero-extended upper bytes leave the XOR unchanged.
    function automatic logic [7:0] xor_chk(input logic [7:0] dtype,
                                           input logic [DATA_MAX_W-1:0] data);
        logic [7:0] c;
        c = dtype;
        for (int i = 0; i < DATA_MAX_W / 8; i++) begin
            c = c ^ data[8*i +: 8];
        end
        return c;
    endfunction

    // Byte k of data, with k = 0 being the least significant byte.
    function automatic logic [7:0] byte_at(input logic [DATA_MAX_W-1:0] data, input int k);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < DATA_MAX_W / 8; i++) begin
            if (k == i) b = data[8*i +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decision_tx_framer.sv
// Buffers trading decisions and serialises each into SOF, type, data (MSB first)
// and an optional XOR checksum on a registered valid/ready byte stream.
module decision_tx_framer
    import framer_pkg::*;
#(
    parameter int         DATA_W       = 32,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter bit         CHK_EN       = 1'b1,
    parameter bit         DROP_ON_FULL = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [7:0]                      in_type,
    input  logic [DATA_W-1:0]               in_data,
    output logic [7:0]                      out_byte,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                     drop_cnt,
    output logic                            busy
);

    localparam int NB    = DATA_W / 8;
    localparam int FW    = 8 + DATA_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rdata;
    decision_t     head_dec;

    fr_state_e     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    hold_t         hold, hold_nxt;
    logic [7:0]    out_byte_nxt;
    logic          out_valid_nxt;
    logic [7:0]    cur_byte;
    logic          load;
    logic          start_frame;
    logic          end_frame;

    assign in_ready  = DROP_ON_FULL ? 1'b1 : !fifo_full;
    assign fifo_push = in_valid && in_ready && !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign head_dec  = '{dtype: fifo_rdata[FW-1 -: 8],
                         data:  DATA_MAX_W'(fifo_rdata[DATA_W-1:0])};

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_type, in_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            SOF:     cur_byte = SOF_BYTE;
            TYPE:    cur_byte = hold.dec.dtype;
            DATA:    cur_byte = byte_at(hold.dec.data, NB - 1 - int'(idx));
            CHK:     cur_byte = hold.chk;
            default: cur_byte = 8'h00;
        endcase
    end

    // The output register takes a new byte whenever it is empty or being consumed;
    // the FSM advances exactly when its current byte is handed over.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt     = state;
        idx_nxt       = idx;
        hold_nxt      = hold;
        out_byte_nxt  = out_byte;
        out_valid_nxt = out_valid;
        fifo_pop      = 1'b0;
        start_frame   = 1'b0;
        end_frame     = 1'b0;
        load          = !out_valid || out_ready;

        if (state == IDLE) begin
            if (load) out_valid_nxt = 1'b0;
            start_frame = !fifo_empty;
        end else if (load) begin
            out_byte_nxt  = cur_byte;
            out_valid_nxt = 1'b1;
            case (state)
                SOF:  state_nxt = TYPE;
                TYPE: begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
                DATA: begin
                    if (idx == IDX_W'(NB - 1)) begin
                        if (CHK_EN) state_nxt = CHK;
                        else        end_frame = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                CHK:     end_frame = 1'b1;
                default: state_nxt = IDLE;
            endcase
        end

        if (end_frame) begin
            state_nxt   = IDLE;
            start_frame = !fifo_empty;
        end

        if (start_frame) begin
            fifo_pop     = 1'b1;
            hold_nxt.dec = head_dec;
            hold_nxt.chk = xor_chk(head_dec.dtype, head_dec.data);
            state_nxt    = SOF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hold      <= '0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hold      <= hold_nxt;
            out_byte  <= out_byte_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'h0000;
        end else if (DROP_ON_FULL && in_valid && fifo_full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end

    generate
        if (!DROP_ON_FULL) begin : g_bp_check
            a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                !(in_valid && in_ready && fifo_full));
        end
    endgenerate

endmodule

// File: tb/tb_decision_tx_framer.sv
// Directed bench for decision_tx_framer: default, drop-on-full and a 16-bit
// no-checksum instance share the clock, reset and out_ready.
module tb_decision_tx_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b0;

    logic        v0 = 1'b0, rdy0, ov0, busy0;
    logic [7:0]  typ0 = '0, ob0;
    logic [31:0] dat0 = '0;
    logic [3:0]  lvl0;
    logic [15:0] dc0;

    logic        v1 = 1'b0, rdy1, ov1, busy1;
    logic [7:0]  typ1 = '0, ob1;
    logic [31:0] dat1 = '0;
    logic [3:0]  lvl1;
    logic [15:0] dc1;

    logic        v2 = 1'b0, rdy2, ov2, busy2;
    logic [7:0]  typ2 = '0, ob2;
    logic [15:0] dat2 = '0;
    logic [3:0]  lvl2;
    logic [15:0] dc2;

    int         tests = 0;
    int         fails = 0;
    int         sel = 0;
    logic       m_valid;
    logic [7:0] m_byte;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    decision_tx_framer dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_type(typ0),
        .in_data(dat0), .out_byte(ob0), .out_valid(ov0), .out_ready(out_ready),
        .fifo_level(lvl0), .drop_cnt(dc0), .busy(busy0)
    );

    decision_tx_framer #(.DROP_ON_FULL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_type(typ1),
        .in_data(dat1), .out_byte(ob1), .out_valid(ov1), .out_ready(out_ready),
        .fifo_level(lvl1), .drop_cnt(dc1), .busy(busy1)
    );

    decision_tx_framer #(.DATA_W(16), .CHK_EN(1'b0), .DROP_ON_FULL(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_type(typ2),
        .in_data(dat2), .out_byte(ob2), .out_valid(ov2), .out_ready(out_ready),
        .fifo_level(lvl2), .drop_cnt(dc2), .busy(busy2)
    );

    always_comb begin
        m_valid = ov2;
        m_byte  = ob2;
        case (sel)
            0: begin m_valid = ov0; m_byte = ob0; end
            1: begin m_valid = ov1; m_byte = ob1; end
            default: begin m_valid = ov2; m_byte = ob2; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] wt(input int n);
        return 8'h10 + 8'(n);
    endfunction

    function automatic logic [31:0] wd(input int n);
        return 32'h01020304 + 32'(n) * 32'h10101010;
    endfunction

    task automatic add_frame(input logic [7:0] t, input logic [63:0] d, input int nb,
                             input bit with_chk);
        logic [7:0] c;
        logic [7:0] b;
        c = t;
        exp_q.push_back(8'hA5);
        exp_q.push_back(t);
        for (int i = nb - 1; i >= 0; i--) begin
            b = d[8*i +: 8];
            exp_q.push_back(b);
            c = c ^ b;
        end
        if (with_chk) exp_q.push_back(c);
    endtask

    task automatic push0(input logic [7:0] t, input logic [31:0] d);
        typ0 = t;
        dat0 = d;
        v0   = 1'b1;
        tick();
        v0   = 1'b0;
    endtask

    // Consumes the expected queue with out_ready high, optionally demanding no idle cycles.
    task automatic drain(input string tag, input int budget, input bit gapless);
        int         gaps;
        int         cyc;
        bit         started;
        logic [7:0] e;
        gaps    = 0;
        cyc     = 0;
        started = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (m_valid) begin
                started = 1'b1;
                e = exp_q.pop_front();
                check(tag, 64'(m_byte), 64'(e));
            end else if (started) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        check({tag, " remaining"}, 64'(exp_q.size()), 64'(0));
        if (gapless) check({tag, " gaps"}, 64'(gaps), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        int         n;
        bit         acc;
        bit         prev_stall;
        logic [7:0] prev_byte;
        logic [7:0] e;

        // Reset values
        tick();
        tick();
        check("rst out_valid", 64'(ov0), 64'(0));
        check("rst out_byte", 64'(ob0), 64'(0));
        check("rst level", 64'(lvl0), 64'(0));
        check("rst drop_cnt", 64'(dc0), 64'(0));
        check("rst busy", 64'(busy0), 64'(0));
        check("rst in_ready m0", 64'(rdy0), 64'(1));
        check("rst in_ready m1", 64'(rdy1), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single frame, latency and checksum
        sel = 0;
        out_ready = 1'b1;
        push0(8'h42, 32'h12345678);
        check("t1 valid@t", 64'(ov0), 64'(0));
        check("t1 level@t", 64'(lvl0), 64'(1));
        check("t1 busy@t", 64'(busy0), 64'(1));
        tick();
        check("t1 valid@t+1", 64'(ov0), 64'(0));
        check("t1 level@t+1", 64'(lvl0), 64'(0));
        tick();
        check("t1 valid@t+2", 64'(ov0), 64'(1));
        check("t1 sof@t+2", 64'(ob0), 64'hA5);
        exp_q = '{8'hA5, 8'h42, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4A};
        drain("t1 byte", 20, 1'b1);
        check("t1 valid end", 64'(ov0), 64'(0));
        check("t1 busy end", 64'(busy0), 64'(0));

        // Same word with out_ready toggling
        out_ready = 1'b0;
        push0(8'h42, 32'h12345678);
        exp_q = '{8'hA5, 8'h42, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4A};
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            out_ready = cyc[0];
            if (prev_stall) check("t2 stall hold", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, prev_byte});
            if (m_valid && out_ready) begin
                e = exp_q.pop_front();
                check("t2 byte", 64'(m_byte), 64'(e));
            end
            prev_stall = m_valid && !out_ready;
            prev_byte  = m_byte;
            tick();
        end
        check("t2 remaining", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        check("t2 valid end", 64'(ov0), 64'(0));
        check("t2 busy end", 64'(busy0), 64'(0));

        // Two words back to back: 14 bytes without a gap
        out_ready = 1'b1;
        typ0 = 8'h42;
        dat0 = 32'h12345678;
        v0   = 1'b1;
        tick();
        typ0 = 8'h07;
        dat0 = 32'hDEADBEEF;
        tick();
        v0   = 1'b0;
        exp_q = '{8'hA5, 8'h42, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4A,
                  8'hA5, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h25};
        drain("t3 byte", 40, 1'b1);
        check("t3 valid end", 64'(ov0), 64'(0));

        // Backpressure mode: 9 words fit with the output stalled
        out_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            typ0 = wt(n);
            dat0 = wd(n);
            v0   = 1'b1;
            acc  = rdy0;
            tick();
            if (acc) n++;
        end
        v0 = 1'b0;
        check("t4 accepted", 64'(n), 64'(9));
        check("t4 in_ready full", 64'(rdy0), 64'(0));
        check("t4 level full", 64'(lvl0), 64'(8));
        check("t4 sof waiting", {55'd0, ov0, ob0}, {55'd0, 1'b1, 8'hA5});
        for (int i = 0; i < 9; i++) add_frame(wt(i), 64'(wd(i)), 4, 1'b1);
        drain("t4 drain", 200, 1'b1);
        check("t4 busy end", 64'(busy0), 64'(0));

        // Drop-on-full mode: 12 pushes, 9 kept, 3 counted
        sel = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            typ1 = wt(i);
            dat1 = wd(i);
            v1   = 1'b1;
            tick();
        end
        v1 = 1'b0;
        check("t5 drop_cnt", 64'(dc1), 64'(3));
        check("t5 level", 64'(lvl1), 64'(8));
        check("t5 in_ready", 64'(rdy1), 64'(1));
        for (int i = 0; i < 9; i++) add_frame(wt(i), 64'(wd(i)), 4, 1'b1);
        drain("t5 drain", 200, 1'b1);
        check("t5 valid end", 64'(ov1), 64'(0));

        // 16-bit data, no checksum: 4-byte frames
        sel = 2;
        out_ready = 1'b1;
        typ2 = 8'h5A;
        dat2 = 16'hC33C;
        v2   = 1'b1;
        tick();
        typ2 = 8'h66;
        dat2 = 16'hBEEF;
        tick();
        v2   = 1'b0;
        exp_q = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'hA5, 8'h66, 8'hBE, 8'hEF};
        drain("t5b byte", 30, 1'b1);
        check("t5b valid end", 64'(ov2), 64'(0));

        // Reset in the middle of a DATA byte with 3 words queued
        sel = 0;
        out_ready = 1'b0;
        typ0 = 8'h33;
        dat0 = 32'hA1B2C3D4;
        v0   = 1'b1;
        tick();
        for (int i = 1; i < 4; i++) begin
            typ0 = wt(i);
            dat0 = wd(i);
            tick();
        end
        v0 = 1'b0;
        check("t6 level", 64'(lvl0), 64'(3));
        check("t6 sof", {55'd0, ov0, ob0}, {55'd0, 1'b1, 8'hA5});
        out_ready = 1'b1;
        tick();
        check("t6 type", 64'(ob0), 64'h33);
        tick();
        check("t6 data msb", 64'(ob0), 64'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", 64'(ov0), 64'(0));
        check("t6 rst level", 64'(lvl0), 64'(0));
        check("t6 rst byte", 64'(ob0), 64'(0));
        check("t6 rst busy", 64'(busy0), 64'(0));
        check("t6 rst drop_cnt", 64'(dc1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6 idle after rst", 64'(ov0), 64'(0));
        push0(8'h42, 32'h12345678);
        exp_q = '{8'hA5, 8'h42, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4A};
        drain("t6 frame", 20, 1'b1);
        check("t6 valid end", 64'(ov0), 64'(0));
        check("t6 level end", 64'(lvl0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decision_tx_framer.md
Name: decision_tx_framer

Overview:
Parametrised framer between the trading-logic decision output and the UART byte transmitter. It buffers decisions in an internal FIFO and serialises each one into a framed byte stream (SOF, type, data bytes MSB-first, optional XOR checksum). It drives a valid/ready byte interface, replacing the single-word, unframed decision path to uart_tx. It supports a blocking or a drop-on-full ingress mode, with a saturating drop counter.

Parameters:
DATA_W, 32, decision data width; a multiple of 8, range 8..64; NB = DATA_W/8.
FIFO_DEPTH, 8, decision FIFO entries; a power of 2, at least 2.
SOF_BYTE, 8'hA5, start-of-frame marker byte.
CHK_EN, 1, 1 = append an XOR checksum byte; 0 = no checksum.
DROP_ON_FULL, 0, 0 = backpressure ingress; 1 = in_ready is tied high and words are dropped when the FIFO is full.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decision word valid
in_ready  out  1  framer can accept a word
in_type  in  8  decision type code
in_data  in  DATA_W  decision data
out_byte  out  8  framed byte to the UART
out_valid  out  1  out_byte valid
out_ready  in  1  UART accepts the byte
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
drop_cnt  out  16  number of dropped words, saturating at 16'hFFFF
busy  out  1  frame in progress or FIFO non-empty

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - out_valid=0, out_byte=0, fifo_level=0, drop_cnt=0, busy=0.
  - FSM in IDLE; FIFO pointers at 0.
  - in_ready=1 in both modes.
- Ingress:
  - A push occurs when in_valid && in_ready.
  - Mode 0: in_ready = !full. A pop in the same cycle does not free space for a push in that cycle.
  - Mode 1: in_ready=1. When in_valid arrives with the FIFO full, the word is discarded and drop_cnt increments, saturating.
- Holding register: the FSM pops the FIFO head into a holding register {type, data, chk}. chk is computed combinationally at load as the XOR of type and all NB data bytes. SOF is excluded from the checksum.
- FSM states: IDLE, SOF, TYPE, DATA, CHK.
  - IDLE: if FIFO non-empty, pop into the holding register and go to SOF. The pop occurs when the state is registered.
  - SOF: out_byte=SOF_BYTE.
  - TYPE: out_byte=type.
  - DATA: out_byte = data byte at index idx; idx counts 0..NB-1, and idx=0 is the most significant byte.
  - CHK: out_byte=chk.
- Advancing: each byte state advances only on out_valid && out_ready.
  - SOF goes to TYPE; TYPE goes to DATA with idx=0.
  - DATA increments idx; on idx=NB-1, go to CHK if CHK_EN, otherwise end the frame.
  - End of frame: if the FIFO is non-empty, pop in the same cycle and go directly to SOF, with no idle gap. Otherwise go to IDLE.
- Output register:
  - out_valid=1 in every state except IDLE.
  - out_byte and out_valid are registered.
  - out_byte must hold stable while out_valid && !out_ready.
- Frame length is 2+NB+CHK_EN bytes (default 7).
- Latency: a word pushed into an empty, idle framer at edge t presents SOF with out_valid=1 after edge t+2.
- Capacity: total buffering is FIFO_DEPTH + 1 (the holding register).
- busy = (state != IDLE) || !empty.
- Reset mid-frame: the frame is aborted immediately, the FIFO is flushed, and all outputs return to reset values. No partial frame resumes after reset.
- Assertion: never push when full in mode 0.

Decomposition:
- Shared package framer_pkg holds:
  - typedef enum fr_state_e {IDLE, SOF, TYPE, DATA, CHK};
  - constant SOF_DEFAULT = 8'hA5;
  - typedef struct decision_t {type, data}.
- One sub-module: sync_fifo, parametrised by width and depth, with full, empty, level, push and pop. It is reusable for the pipeline_regs rework.

Test Plan:
- Defaults, out_ready=1, push type 0x42 data 0x12345678 -> bytes A5 42 12 34 56 78 4A on 7 consecutive cycles, SOF after edge t+2; busy then drops to 0.
- Same word, out_ready toggling 1/0 every cycle -> identical byte sequence; out_byte stable through every stalled cycle; no byte lost or duplicated.
- Two words pushed on back-to-back cycles, out_ready=1 -> 14 consecutive out_valid cycles with no gap; second frame starts A5 immediately after the first frame's checksum.
- Mode 0, out_ready=0, in_valid held high -> exactly 9 words accepted (8 in FIFO + 1 holding); in_ready=0 with fifo_level=8; then out_ready=1 drains 63 bytes in order.
- Mode 1, out_ready=0, 12 pushes -> 9 accepted, drop_cnt=3; drain yields words 1..9 only; CHK_EN=0, DATA_W=16 variant yields 4-byte frames A5 type d1 d0.
- rst_n asserted during a DATA byte with 3 words queued -> out_valid=0 and fifo_level=0 immediately; after release, a new word produces a clean full frame.
